axi_arb2: RTL and testbench
===========================

# axi_arb2

Two-initiator AXI3 arbiter sharing one `axi_if` target between two initiators.
- Read and write channels are arbitrated independently, each with round-robin grant and one outstanding burst per direction.
- The grant is held from address acceptance until the burst completes (write: B handshake; read: RLAST).
- It sits between two bus masters (e.g. CPU and DMA) and a single memory/peripheral port; IDs pass through unmodified.

## Interface
Parameters (forwarded to all three `axi_if` instances; widths must match):
- `AXI_ID_W`, 8, ID width
- `AXI_ADDR_W`, 32, address width
- `AXI_DATA_W`, 32, data width

Ports:
- `ACLK` input 1 — single clock; all logic on rising edge
- `ARESET` input 1 — asynchronous, active-high reset
- `s0` `axi_if.target` — initiator 0 (priority on first-ever tie)
- `s1` `axi_if.target` — initiator 1
- `m` `axi_if.initiator` — shared target
- `wr_gnt` output 2 — one-hot current write owner, 00 when idle (debug/perf)
- `rd_gnt` output 2 — one-hot current read owner, 00 when idle

## Operation
Write FSM: W_IDLE, W_ADDR, W_DATA, W_RESP.
- **W_IDLE**
  - If any `sN.AWVALID`, register the winner and go to W_ADDR.
  - Winner: a sole requester wins. On a tie, the initiator other than `wr_last` wins. `wr_last` resets to 1, so s0 wins the first tie.
- **W_ADDR**
  - `m.AW*` = winner's AW fields; `m.AWVALID` = winner's AWVALID; winner's `AWREADY` = `m.AWREADY`.
  - On `m.AWVALID && m.AWREADY`, go to W_DATA.
- **W_DATA**
  - W channel muxed from the winner; winner's `WREADY` = `m.WREADY`.
  - On a W handshake with `WLAST`=1, go to W_RESP.
- **W_RESP**
  - `m.BREADY` = winner's `BREADY`; winner's `BID`/`BRESP`/`BVALID` driven from `m`.
  - On the B handshake: `wr_last` <= winner, go to W_IDLE.

Read FSM: R_IDLE, R_ADDR, R_DATA.
- Same arbitration as the write FSM, using `rd_last`.
- **R_ADDR**: AR channel muxed from the winner.
- **R_DATA**: R channel routed to the winner. On an R handshake with `RLAST`=1: `rd_last` <= winner, go to R_IDLE.

Non-owners and idle states:
- The non-owner initiator always sees `AWREADY`/`WREADY`/`ARREADY`=0 and `BVALID`/`RVALID`=0.
- Outside the relevant state, `m.AWVALID`/`m.WVALID`/`m.ARVALID`/`m.BREADY`/`m.RREADY` = 0.
- Muxed payload fields toward `m` are 0 when no grant is held.
- W data offered before the AW is accepted is stalled (WREADY=0). This is legal per AXI.

Reset values: both FSMs in IDLE; `wr_last`=`rd_last`=1; `wr_gnt`=`rd_gnt`=00. All ready/valid outputs on `s0`, `s1` and `m` are 0; all payload outputs are 0.

## Timing
- Arbitration latency: `sN.AWVALID`/`ARVALID` first high in cycle t → `m.AWVALID`/`ARVALID` high in cycle t+1.
- Within a granted state all paths are combinational pass-through, adding no cycles per beat.
- Burst completion → IDLE next cycle. A pending request from the other initiator then appears on `m` two cycles after completion (IDLE → ADDR), so the bus is dead for one cycle.
- A request deasserting in IDLE before registration is simply not granted. A request is never withdrawn in ADDR, per AXI rules.
- Read and write FSMs may grant different initiators simultaneously.
- `ARESET` asserted mid-burst: immediate return to reset values. Partial bursts are abandoned; system reset covers both sides.
- A single-beat burst (LEN=0, WLAST/RLAST on first beat) must complete correctly.

## Structure
- Package `axi_arb_pkg`:
  - enums `wr_state_t` and `rd_state_t`
  - function `rr_pick(req[1:0], last)` returning the one-hot grant
- Natural sub-module: `axi_arb_rr2`. This is a 2-way round-robin picker with a registered `last` pointer, instantiated once for write and once for read.
- Channel muxing stays in `axi_arb2`.

## Test plan
- **Reset:** assert `ARESET` mid-write → all valids/readies 0, `wr_gnt`=00 in the same cycle; after release s0 AW at t gives `m.AWVALID` at t+1.
- **Tie:** s0 and s1 both issue AW (LEN=3) at once → s0 granted, 4 beats plus B routed to s0 only. s1 is then granted 2 cycles after s0's B handshake; a further simultaneous tie goes to s0.
- **Concurrent read/write:** s1 write LEN=0 while s0 read LEN=7 → both proceed concurrently; `wr_gnt`=10, `rd_gnt`=01; s0 gets 8 R beats, RLAST on the 8th.
- **Early W:** s0 drives WVALID 3 cycles before AWVALID → `s0.WREADY`=0 until W_DATA; data arrives at `m` intact with WSTRB preserved.
- **Backpressure:** `m.RREADY` tied to s1 RREADY toggling every cycle, `m` RVALID held → each beat accepted only when RREADY=1; s0 sees `RVALID`=0 throughout.
- **ID passthrough:** s1 ARID=0xA5 → `m.ARID`=0xA5; returned RID=0xA5 delivered only to s1.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and the round-robin pick function for the two-initiator
// AXI3 arbiter.
//   wr_state_t / rd_state_t : write and read channel FSM states
//   rr_pick(req, last)      : one-hot grant; on a tie the side that was
//                             not served last wins
package axi_arb_pkg;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    return gnt;
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI3 bundle (AW, W, B, AR, R) without the optional sideband fields.
//   target    : seen by a component that accepts transactions
//   initiator : seen by a component that issues transactions
interface axi_if #(
  parameter int AXI_ID_W   = 8,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
);
  logic [AXI_ID_W-1:0]     AWID;
  logic [AXI_ADDR_W-1:0]   AWADDR;
  logic [3:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID, AWREADY;
  logic [AXI_ID_W-1:0]     WID;
  logic [AXI_DATA_W-1:0]   WDATA;
  logic [AXI_DATA_W/8-1:0] WSTRB;
  logic                    WLAST, WVALID, WREADY;
  logic [AXI_ID_W-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID, BREADY;
  logic [AXI_ID_W-1:0]     ARID;
  logic [AXI_ADDR_W-1:0]   ARADDR;
  logic [3:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID, ARREADY;
  logic [AXI_ID_W-1:0]     RID;
  logic [AXI_DATA_W-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST, RVALID, RREADY;

  modport target (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );

  modport initiator (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );
endinterface

// File: rtl/axi_arb_rr2.sv
// Two-way round-robin picker.
//   clk, rst : clock, async active-high reset
//   req      : request vector {s1, s0}
//   done     : burst complete; load owner into the last-served pointer
//   owner    : index of the initiator currently holding the grant
//   gnt      : combinational one-hot pick for the current cycle
module axi_arb_rr2
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       owner,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (done) last_d = owner;
  end

  // Pointer resets to 1 so initiator 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  assign gnt = rr_pick(req, last_q);

endmodule

// File: rtl/axi_arb2.sv
// Two-initiator AXI3 arbiter onto one shared target. Read and write
// channels each hold a grant from address acceptance until the burst
// completes (B handshake / RLAST). IDs pass through unmodified.
//   ACLK, ARESET   : clock, async active-high reset
//   s0, s1         : initiator-facing ports (s0 wins the first tie)
//   m              : shared target port
//   wr_gnt, rd_gnt : one-hot current owner per direction, 00 when idle
//
// state  | meaning
// W_IDLE | no write owner; arbitrate AWVALID
// W_ADDR | owner's AW forwarded until accepted
// W_DATA | owner's W forwarded until WLAST handshake
// W_RESP | B routed back to owner until handshake
// R_IDLE | no read owner; arbitrate ARVALID
// R_ADDR | owner's AR forwarded until accepted
// R_DATA | R routed to owner until RLAST handshake
module axi_arb2
  import axi_arb_pkg::*;
#(
  parameter int AXI_ID_W   = 8,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32
) (
  input  logic       ACLK,
  input  logic       ARESET,
  axi_if.target      s0,
  axi_if.target      s1,
  axi_if.initiator   m,
  output logic [1:0] wr_gnt,
  output logic [1:0] rd_gnt
);

  localparam int STRB_W = AXI_DATA_W / 8;

  wr_state_t  wr_state_q, wr_state_d;
  rd_state_t  rd_state_q, rd_state_d;
  logic       wr_own_q, wr_own_d, rd_own_q, rd_own_d;
  logic       wr_done, rd_done;
  logic [1:0] wr_pick, rd_pick;

  axi_arb_rr2 u_wr_rr (
    .clk(ACLK), .rst(ARESET), .req({s1.AWVALID, s0.AWVALID}),
    .done(wr_done), .owner(wr_own_q), .gnt(wr_pick)
  );

  axi_arb_rr2 u_rd_rr (
    .clk(ACLK), .rst(ARESET), .req({s1.ARVALID, s0.ARVALID}),
    .done(rd_done), .owner(rd_own_q), .gnt(rd_pick)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_own_q   <= 1'b0;
      rd_own_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_own_q   <= wr_own_d;
      rd_own_q   <= rd_own_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_own_d   = wr_own_q;
    wr_done    = 1'b0;
    unique case (wr_state_q)
      W_IDLE: if (|wr_pick) begin
        wr_own_d   = wr_pick[1];
        wr_state_d = W_ADDR;
      end
      W_ADDR: if (m.AWVALID && m.AWREADY) wr_state_d = W_DATA;
      W_DATA: if (m.WVALID && m.WREADY && m.WLAST) wr_state_d = W_RESP;
      W_RESP: if (m.BVALID && m.BREADY) begin
        wr_done    = 1'b1;
        wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_own_d   = rd_own_q;
    rd_done    = 1'b0;
    unique case (rd_state_q)
      R_IDLE: if (|rd_pick) begin
        rd_own_d   = rd_pick[1];
        rd_state_d = R_ADDR;
      end
      R_ADDR: if (m.ARVALID && m.ARREADY) rd_state_d = R_DATA;
      R_DATA: if (m.RVALID && m.RREADY && m.RLAST) begin
        rd_done    = 1'b1;
        rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  logic wr_hold, aw_st, w_st, b_st, rd_hold, ar_st, r_st;
  assign wr_hold = (wr_state_q != W_IDLE);
  assign aw_st   = (wr_state_q == W_ADDR);
  assign w_st    = (wr_state_q == W_DATA);
  assign b_st    = (wr_state_q == W_RESP);
  assign rd_hold = (rd_state_q != R_IDLE);
  assign ar_st   = (rd_state_q == R_ADDR);
  assign r_st    = (rd_state_q == R_DATA);

  assign wr_gnt = wr_hold ? (wr_own_q ? 2'b10 : 2'b01) : 2'b00;
  assign rd_gnt = rd_hold ? (rd_own_q ? 2'b10 : 2'b01) : 2'b00;

  // Write path: payload follows the owner for the whole grant; handshakes
  // are gated to the phase, so early W data stays stalled in W_ADDR.
  assign m.AWID    = wr_hold ? (wr_own_q ? s1.AWID    : s0.AWID)    : {AXI_ID_W{1'b0}};
  assign m.AWADDR  = wr_hold ? (wr_own_q ? s1.AWADDR  : s0.AWADDR)  : {AXI_ADDR_W{1'b0}};
  assign m.AWLEN   = wr_hold ? (wr_own_q ? s1.AWLEN   : s0.AWLEN)   : 4'd0;
  assign m.AWSIZE  = wr_hold ? (wr_own_q ? s1.AWSIZE  : s0.AWSIZE)  : 3'd0;
  assign m.AWBURST = wr_hold ? (wr_own_q ? s1.AWBURST : s0.AWBURST) : 2'd0;
  assign m.AWVALID = aw_st & (wr_own_q ? s1.AWVALID : s0.AWVALID);
  assign s0.AWREADY = aw_st & ~wr_own_q & m.AWREADY;
  assign s1.AWREADY = aw_st &  wr_own_q & m.AWREADY;

  assign m.WID    = wr_hold ? (wr_own_q ? s1.WID   : s0.WID)   : {AXI_ID_W{1'b0}};
  assign m.WDATA  = wr_hold ? (wr_own_q ? s1.WDATA : s0.WDATA) : {AXI_DATA_W{1'b0}};
  assign m.WSTRB  = wr_hold ? (wr_own_q ? s1.WSTRB : s0.WSTRB) : {STRB_W{1'b0}};
  assign m.WLAST  = wr_hold & (wr_own_q ? s1.WLAST : s0.WLAST);
  assign m.WVALID = w_st & (wr_own_q ? s1.WVALID : s0.WVALID);
  assign s0.WREADY = w_st & ~wr_own_q & m.WREADY;
  assign s1.WREADY = w_st &  wr_own_q & m.WREADY;

  assign m.BREADY  = b_st & (wr_own_q ? s1.BREADY : s0.BREADY);
  assign s0.BVALID = b_st & ~wr_own_q & m.BVALID;
  assign s1.BVALID = b_st &  wr_own_q & m.BVALID;
  assign s0.BID    = (b_st & ~wr_own_q) ? m.BID   : {AXI_ID_W{1'b0}};
  assign s1.BID    = (b_st &  wr_own_q) ? m.BID   : {AXI_ID_W{1'b0}};
  assign s0.BRESP  = (b_st & ~wr_own_q) ? m.BRESP : 2'd0;
  assign s1.BRESP  = (b_st &  wr_own_q) ? m.BRESP : 2'd0;

  assign m.ARID    = rd_hold ? (rd_own_q ? s1.ARID    : s0.ARID)    : {AXI_ID_W{1'b0}};
  assign m.ARADDR  = rd_hold ? (rd_own_q ? s1.ARADDR  : s0.ARADDR)  : {AXI_ADDR_W{1'b0}};
  assign m.ARLEN   = rd_hold ? (rd_own_q ? s1.ARLEN   : s0.ARLEN)   : 4'd0;
  assign m.ARSIZE  = rd_hold ? (rd_own_q ? s1.ARSIZE  : s0.ARSIZE)  : 3'd0;
  assign m.ARBURST = rd_hold ? (rd_own_q ? s1.ARBURST : s0.ARBURST) : 2'd0;
  assign m.ARVALID = ar_st & (rd_own_q ? s1.ARVALID : s0.ARVALID);
  assign s0.ARREADY = ar_st & ~rd_own_q & m.ARREADY;
  assign s1.ARREADY = ar_st &  rd_own_q & m.ARREADY;

  assign m.RREADY  = r_st & (rd_own_q ? s1.RREADY : s0.RREADY);
  assign s0.RVALID = r_st & ~rd_own_q & m.RVALID;
  assign s1.RVALID = r_st &  rd_own_q & m.RVALID;
  assign s0.RID    = (r_st & ~rd_own_q) ? m.RID   : {AXI_ID_W{1'b0}};
  assign s1.RID    = (r_st &  rd_own_q) ? m.RID   : {AXI_ID_W{1'b0}};
  assign s0.RDATA  = (r_st & ~rd_own_q) ? m.RDATA : {AXI_DATA_W{1'b0}};
  assign s1.RDATA  = (r_st &  rd_own_q) ? m.RDATA : {AXI_DATA_W{1'b0}};
  assign s0.RRESP  = (r_st & ~rd_own_q) ? m.RRESP : 2'd0;
  assign s1.RRESP  = (r_st &  rd_own_q) ? m.RRESP : 2'd0;
  assign s0.RLAST  = r_st & ~rd_own_q & m.RLAST;
  assign s1.RLAST  = r_st &  rd_own_q & m.RLAST;

endmodule

// File: tb/tb_axi_arb2.sv
module tb_axi_arb2;

  logic       ACLK   = 1'b0;
  logic       ARESET = 1'b1;
  logic [1:0] wr_gnt, rd_gnt;
  int         total = 0;
  int         bad   = 0;

  logic [31:0] exp_wd_q[$];
  logic [3:0]  exp_ws_q[$];
  logic        exp_wl_q[$];
  logic [31:0] exp_rd_q[$];
  logic        exp_rl_q[$];

  axi_if #(.AXI_ID_W(8), .AXI_ADDR_W(32), .AXI_DATA_W(32)) s0_if ();
  axi_if #(.AXI_ID_W(8), .AXI_ADDR_W(32), .AXI_DATA_W(32)) s1_if ();
  axi_if #(.AXI_ID_W(8), .AXI_ADDR_W(32), .AXI_DATA_W(32)) m_if ();

  axi_arb2 #(.AXI_ID_W(8), .AXI_ADDR_W(32), .AXI_DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s0(s0_if), .s1(s1_if), .m(m_if),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic clk1();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.AWID = '0; s0_if.AWADDR = '0; s0_if.AWLEN = '0; s0_if.AWSIZE = 3'd2; s0_if.AWBURST = 2'd1; s0_if.AWVALID = 0;
    s0_if.WID = '0; s0_if.WDATA = '0; s0_if.WSTRB = '0; s0_if.WLAST = 0; s0_if.WVALID = 0; s0_if.BREADY = 0;
    s0_if.ARID = '0; s0_if.ARADDR = '0; s0_if.ARLEN = '0; s0_if.ARSIZE = 3'd2; s0_if.ARBURST = 2'd1; s0_if.ARVALID = 0;
    s0_if.RREADY = 0;
    s1_if.AWID = '0; s1_if.AWADDR = '0; s1_if.AWLEN = '0; s1_if.AWSIZE = 3'd2; s1_if.AWBURST = 2'd1; s1_if.AWVALID = 0;
    s1_if.WID = '0; s1_if.WDATA = '0; s1_if.WSTRB = '0; s1_if.WLAST = 0; s1_if.WVALID = 0; s1_if.BREADY = 0;
    s1_if.ARID = '0; s1_if.ARADDR = '0; s1_if.ARLEN = '0; s1_if.ARSIZE = 3'd2; s1_if.ARBURST = 2'd1; s1_if.ARVALID = 0;
    s1_if.RREADY = 0;
    m_if.AWREADY = 0; m_if.WREADY = 0; m_if.ARREADY = 0;
    m_if.BID = '0; m_if.BRESP = '0; m_if.BVALID = 0;
    m_if.RID = '0; m_if.RDATA = '0; m_if.RRESP = '0; m_if.RLAST = 0; m_if.RVALID = 0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    clear_inputs();
    clk1();
    clk1();
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    clear_inputs();
    m_if.AWREADY = 1; m_if.WREADY = 1; m_if.ARREADY = 1;
    s0_if.AWVALID = 1; s0_if.AWADDR = 32'h55; s0_if.WVALID = 1; s0_if.ARVALID = 1;
    clk1(); #2;
    total++; if (wr_gnt !== 2'b00) begin bad++; $display("FAIL rst_wr_gnt got=%b exp=00", wr_gnt); end
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("FAIL rst_rd_gnt got=%b exp=00", rd_gnt); end
    total++; if (m_if.AWVALID !== 1'b0) begin bad++; $display("FAIL rst_m_awvalid got=%b exp=0", m_if.AWVALID); end
    total++; if (m_if.ARVALID !== 1'b0) begin bad++; $display("FAIL rst_m_arvalid got=%b exp=0", m_if.ARVALID); end
    total++; if (s0_if.AWREADY !== 1'b0) begin bad++; $display("FAIL rst_s0_awready got=%b exp=0", s0_if.AWREADY); end
    total++; if (s0_if.WREADY !== 1'b0) begin bad++; $display("FAIL rst_s0_wready got=%b exp=0", s0_if.WREADY); end
    total++; if (m_if.AWADDR !== 32'h0) begin bad++; $display("FAIL rst_m_awaddr got=%h exp=0", m_if.AWADDR); end
    clk1();
    ARESET = 1'b0;
    clear_inputs();
    s0_if.AWVALID = 1; s0_if.AWADDR = 32'h10; s0_if.AWLEN = 4'd1;
    clk1();
    m_if.AWREADY = 1;
    clk1();
    s0_if.AWVALID = 0; m_if.AWREADY = 0;
    s0_if.WVALID = 1; s0_if.WDATA = 32'h1111_0000; s0_if.WSTRB = 4'hF; s0_if.WLAST = 0; m_if.WREADY = 1;
    #2;
    total++; if (m_if.WVALID !== 1'b1) begin bad++; $display("FAIL rst_pre_wvalid got=%b exp=1", m_if.WVALID); end
    #1 ARESET = 1'b1;
    #1;
    total++; if (m_if.WVALID !== 1'b0) begin bad++; $display("FAIL rst_mid_m_wvalid got=%b exp=0", m_if.WVALID); end
    total++; if (s0_if.WREADY !== 1'b0) begin bad++; $display("FAIL rst_mid_s0_wready got=%b exp=0", s0_if.WREADY); end
    total++; if (wr_gnt !== 2'b00) begin bad++; $display("FAIL rst_mid_wr_gnt got=%b exp=00", wr_gnt); end
    clk1();
    ARESET = 1'b0;
    clear_inputs();
    clk1();
    s0_if.AWVALID = 1; s0_if.AWADDR = 32'h20;
    #2;
    total++; if (m_if.AWVALID !== 1'b0) begin bad++; $display("FAIL rst_lat_t got=%b exp=0", m_if.AWVALID); end
    clk1(); #2;
    total++; if (m_if.AWVALID !== 1'b1) begin bad++; $display("FAIL rst_lat_t1 got=%b exp=1", m_if.AWVALID); end
    total++; if (m_if.AWADDR !== 32'h20) begin bad++; $display("FAIL rst_lat_addr got=%h exp=20", m_if.AWADDR); end
  endtask

  task automatic test_tie();
    logic [31:0] e;
    logic        l;
    do_reset();
    clk1();
    s0_if.AWVALID = 1; s0_if.AWID = 8'h01; s0_if.AWADDR = 32'h100; s0_if.AWLEN = 4'd3;
    s1_if.AWVALID = 1; s1_if.AWID = 8'h02; s1_if.AWADDR = 32'h200; s1_if.AWLEN = 4'd3;
    #2;
    total++; if (wr_gnt !== 2'b00) begin bad++; $display("FAIL tie_idle_gnt got=%b exp=00", wr_gnt); end
    for (int k = 0; k < 2; k++) begin
      clk1();
      m_if.AWREADY = 1;
      #2;
      total++; if (wr_gnt !== ((k == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL tie_gnt k=%0d got=%b", k, wr_gnt); end
      total++; if (m_if.AWADDR !== ((k == 0) ? 32'h100 : 32'h200)) begin bad++; $display("FAIL tie_awaddr k=%0d got=%h", k, m_if.AWADDR); end
      total++; if (((k == 0) ? s1_if.AWREADY : s0_if.AWREADY) !== 1'b0) begin bad++; $display("FAIL tie_nonowner_awready k=%0d got=1 exp=0", k); end
      clk1();
      m_if.AWREADY = 0; m_if.WREADY = 1;
      if (k == 0) s0_if.AWVALID = 0; else s1_if.AWVALID = 0;
      for (int i = 0; i < 4; i++) begin
        s0_if.WVALID = 1; s0_if.WDATA = 32'hD000_0000 | 32'(i); s0_if.WLAST = (i == 3); s0_if.WSTRB = 4'hF;
        s1_if.WVALID = 1; s1_if.WDATA = 32'hD000_0100 | 32'(i); s1_if.WLAST = (i == 3); s1_if.WSTRB = 4'hF;
        exp_wd_q.push_back(32'hD000_0000 | 32'(k << 8) | 32'(i));
        exp_wl_q.push_back(i == 3);
        #2;
        total++; if (((k == 0) ? s1_if.WREADY : s0_if.WREADY) !== 1'b0) begin bad++; $display("FAIL tie_nonowner_wready k=%0d i=%0d got=1 exp=0", k, i); end
        total++;
        if (m_if.WVALID !== 1'b1) begin
          bad++; $display("FAIL tie_m_wvalid k=%0d i=%0d got=%b exp=1", k, i, m_if.WVALID);
        end else begin
          e = exp_wd_q.pop_front();
          l = exp_wl_q.pop_front();
          total++; if (m_if.WDATA !== e) begin bad++; $display("FAIL tie_wdata k=%0d i=%0d got=%h exp=%h", k, i, m_if.WDATA, e); end
          total++; if (m_if.WLAST !== l) begin bad++; $display("FAIL tie_wlast k=%0d i=%0d got=%b exp=%b", k, i, m_if.WLAST, l); end
        end
        clk1();
      end
      s0_if.WVALID = 0; s0_if.WLAST = 0; s1_if.WVALID = 0; s1_if.WLAST = 0; m_if.WREADY = 0;
      m_if.BVALID = 1; m_if.BID = (k == 0) ? 8'h01 : 8'h02; s0_if.BREADY = 1; s1_if.BREADY = 1;
      #2;
      total++; if (((k == 0) ? s0_if.BVALID : s1_if.BVALID) !== 1'b1) begin bad++; $display("FAIL tie_owner_bvalid k=%0d got=0 exp=1", k); end
      total++; if (((k == 0) ? s0_if.BID : s1_if.BID) !== ((k == 0) ? 8'h01 : 8'h02)) begin bad++; $display("FAIL tie_owner_bid k=%0d", k); end
      total++; if (((k == 0) ? s1_if.BVALID : s0_if.BVALID) !== 1'b0) begin bad++; $display("FAIL tie_nonowner_bvalid k=%0d got=1 exp=0", k); end
      clk1();
      m_if.BVALID = 0;
      #2;
      total++; if (wr_gnt !== 2'b00) begin bad++; $display("FAIL tie_dead_gnt k=%0d got=%b exp=00", k, wr_gnt); end
      total++; if (m_if.AWVALID !== 1'b0) begin bad++; $display("FAIL tie_dead_awvalid k=%0d got=1 exp=0", k); end
    end
    clk1();
    s0_if.AWVALID = 1; s1_if.AWVALID = 1;
    clk1(); #2;
    total++; if (wr_gnt !== 2'b01) begin bad++; $display("FAIL tie_second_gnt got=%b exp=01", wr_gnt); end
  endtask

  task automatic test_concurrent();
    logic [31:0] e;
    logic        l;
    do_reset();
    clk1();
    s1_if.AWVALID = 1; s1_if.AWID = 8'h03; s1_if.AWADDR = 32'h300; s1_if.AWLEN = 4'd0;
    s0_if.ARVALID = 1; s0_if.ARID = 8'h04; s0_if.ARADDR = 32'h400; s0_if.ARLEN = 4'd7;
    clk1();
    m_if.AWREADY = 1; m_if.ARREADY = 1;
    #2;
    total++; if (wr_gnt !== 2'b10) begin bad++; $display("FAIL cc_wr_gnt got=%b exp=10", wr_gnt); end
    total++; if (rd_gnt !== 2'b01) begin bad++; $display("FAIL cc_rd_gnt got=%b exp=01", rd_gnt); end
    total++; if (m_if.ARID !== 8'h04) begin bad++; $display("FAIL cc_arid got=%h exp=04", m_if.ARID); end
    total++; if (m_if.AWID !== 8'h03) begin bad++; $display("FAIL cc_awid got=%h exp=03", m_if.AWID); end
    clk1();
    s1_if.AWVALID = 0; s0_if.ARVALID = 0; m_if.AWREADY = 0; m_if.ARREADY = 0;
    s1_if.WVALID = 1; s1_if.WDATA = 32'h5151_5151; s1_if.WSTRB = 4'hF; s1_if.WLAST = 1; m_if.WREADY = 1;
    exp_wd_q.push_back(32'h5151_5151);
    s0_if.RREADY = 1;
    for (int i = 0; i < 8; i++) begin
      exp_rd_q.push_back(32'hA000_0000 | 32'(i));
      exp_rl_q.push_back(i == 7);
    end
    for (int i = 0; i < 8; i++) begin
      m_if.RVALID = 1; m_if.RID = 8'h04; m_if.RDATA = 32'hA000_0000 | 32'(i); m_if.RLAST = (i == 7);
      if (i == 1) begin
        s1_if.WVALID = 0; s1_if.WLAST = 0; m_if.WREADY = 0;
        m_if.BVALID = 1; m_if.BID = 8'h03; s1_if.BREADY = 1;
      end
      if (i == 2) m_if.BVALID = 0;
      #2;
      e = exp_rd_q.pop_front();
      l = exp_rl_q.pop_front();
      total++; if (s0_if.RVALID !== 1'b1) begin bad++; $display("FAIL cc_s0_rvalid i=%0d got=0 exp=1", i); end
      total++; if (s0_if.RDATA !== e) begin bad++; $display("FAIL cc_s0_rdata i=%0d got=%h exp=%h", i, s0_if.RDATA, e); end
      total++; if (s0_if.RLAST !== l) begin bad++; $display("FAIL cc_s0_rlast i=%0d got=%b exp=%b", i, s0_if.RLAST, l); end
      total++; if (s1_if.RVALID !== 1'b0) begin bad++; $display("FAIL cc_s1_rvalid i=%0d got=1 exp=0", i); end
      if (i == 0) begin
        e = exp_wd_q.pop_front();
        total++; if (m_if.WVALID !== 1'b1) begin bad++; $display("FAIL cc_m_wvalid got=0 exp=1"); end
        total++; if (m_if.WDATA !== e) begin bad++; $display("FAIL cc_m_wdata got=%h exp=%h", m_if.WDATA, e); end
      end
      if (i == 1) begin
        total++; if (s1_if.BVALID !== 1'b1) begin bad++; $display("FAIL cc_s1_bvalid got=0 exp=1"); end
        total++; if (s1_if.BID !== 8'h03) begin bad++; $display("FAIL cc_s1_bid got=%h exp=03", s1_if.BID); end
      end
      clk1();
    end
    m_if.RVALID = 0; m_if.RLAST = 0;
    #2;
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("FAIL cc_rd_done_gnt got=%b exp=00", rd_gnt); end
    total++; if (wr_gnt !== 2'b00) begin bad++; $display("FAIL cc_wr_done_gnt got=%b exp=00", wr_gnt); end
  endtask

  task automatic test_early_w();
    logic [31:0] e;
    logic [3:0]  s;
    do_reset();
    clk1();
    s0_if.WVALID = 1; s0_if.WDATA = 32'hCAFE_BABE; s0_if.WSTRB = 4'b0101; s0_if.WLAST = 1; m_if.WREADY = 1;
    exp_wd_q.push_back(32'hCAFE_BABE);
    exp_ws_q.push_back(4'b0101);
    for (int j = 0; j < 3; j++) begin
      #2;
      total++; if (s0_if.WREADY !== 1'b0) begin bad++; $display("FAIL ew_pre_wready j=%0d got=1 exp=0", j); end
      total++; if (m_if.WVALID !== 1'b0) begin bad++; $display("FAIL ew_pre_m_wvalid j=%0d got=1 exp=0", j); end
      clk1();
    end
    s0_if.AWVALID = 1; s0_if.AWADDR = 32'h500; s0_if.AWLEN = 4'd0;
    clk1();
    m_if.AWREADY = 1;
    #2;
    total++; if (s0_if.WREADY !== 1'b0) begin bad++; $display("FAIL ew_addr_wready got=1 exp=0"); end
    clk1();
    s0_if.AWVALID = 0; m_if.AWREADY = 0;
    #2;
    e = exp_wd_q.pop_front();
    s = exp_ws_q.pop_front();
    total++; if (s0_if.WREADY !== 1'b1) begin bad++; $display("FAIL ew_data_wready got=0 exp=1"); end
    total++; if (m_if.WDATA !== e) begin bad++; $display("FAIL ew_wdata got=%h exp=%h", m_if.WDATA, e); end
    total++; if (m_if.WSTRB !== s) begin bad++; $display("FAIL ew_wstrb got=%b exp=%b", m_if.WSTRB, s); end
    clk1();
    s0_if.WVALID = 0;
    #2;
    total++; if (wr_gnt !== 2'b01) begin bad++; $display("FAIL ew_resp_gnt got=%b exp=01", wr_gnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    int          b;
    b = 0;
    do_reset();
    clk1();
    s1_if.ARVALID = 1; s1_if.ARID = 8'h07; s1_if.ARADDR = 32'h700; s1_if.ARLEN = 4'd3;
    for (int i = 0; i < 4; i++) exp_rd_q.push_back(32'hB000_0000 | 32'(i));
    clk1();
    m_if.ARREADY = 1;
    #2;
    total++; if (rd_gnt !== 2'b10) begin bad++; $display("FAIL bp_rd_gnt got=%b exp=10", rd_gnt); end
    clk1();
    s1_if.ARVALID = 0; m_if.ARREADY = 0;
    for (int i = 0; i < 20 && b < 4; i++) begin
      m_if.RVALID = 1; m_if.RID = 8'h07; m_if.RDATA = 32'hB000_0000 | 32'(b); m_if.RLAST = (b == 3);
      s1_if.RREADY = i[0];
      s0_if.RREADY = 1;
      #2;
      total++; if (m_if.RREADY !== s1_if.RREADY) begin bad++; $display("FAIL bp_m_rready i=%0d got=%b exp=%b", i, m_if.RREADY, s1_if.RREADY); end
      total++; if (s0_if.RVALID !== 1'b0) begin bad++; $display("FAIL bp_s0_rvalid i=%0d got=1 exp=0", i); end
      if (s1_if.RREADY) begin
        e = exp_rd_q.pop_front();
        total++; if (s1_if.RDATA !== e) begin bad++; $display("FAIL bp_s1_rdata b=%0d got=%h exp=%h", b, s1_if.RDATA, e); end
        b++;
      end
      clk1();
    end
    total++; if (b !== 4) begin bad++; $display("FAIL bp_beats got=%0d exp=4", b); end
    m_if.RVALID = 0; m_if.RLAST = 0;
    #2;
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("FAIL bp_done_gnt got=%b exp=00", rd_gnt); end
  endtask

  task automatic test_id_passthrough();
    do_reset();
    clk1();
    s1_if.ARVALID = 1; s1_if.ARID = 8'hA5; s1_if.ARADDR = 32'h800; s1_if.ARLEN = 4'd0;
    clk1();
    m_if.ARREADY = 1;
    #2;
    total++; if (m_if.ARID !== 8'hA5) begin bad++; $display("FAIL id_m_arid got=%h exp=a5", m_if.ARID); end
    clk1();
    s1_if.ARVALID = 0; m_if.ARREADY = 0;
    m_if.RVALID = 1; m_if.RID = 8'hA5; m_if.RDATA = 32'h1234; m_if.RLAST = 1;
    s0_if.RREADY = 1; s1_if.RREADY = 1;
    #2;
    total++; if (s1_if.RID !== 8'hA5) begin bad++; $display("FAIL id_s1_rid got=%h exp=a5", s1_if.RID); end
    total++; if (s1_if.RVALID !== 1'b1) begin bad++; $display("FAIL id_s1_rvalid got=0 exp=1"); end
    total++; if (s0_if.RVALID !== 1'b0) begin bad++; $display("FAIL id_s0_rvalid got=1 exp=0"); end
    total++; if (s0_if.RID !== 8'h00) begin bad++; $display("FAIL id_s0_rid got=%h exp=00", s0_if.RID); end
    clk1();
    m_if.RVALID = 0; m_if.RLAST = 0;
    #2;
    total++; if (rd_gnt !== 2'b00) begin bad++; $display("FAIL id_done_gnt got=%b exp=00", rd_gnt); end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_concurrent();
    test_early_w();
    test_backpressure();
    test_id_passthrough();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before test sequence completed");
    $fatal(1);
  end

endmodule
